// File: rtl/debounce_sync.sv
// Synchronizes and debounces a raw bouncy input into a clean level plus rise/fall pulses.
// Optional macro DEBOUNCE_FALL_PULSE_EN builds the fall pulse register; otherwise fall is 0.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_MAX     = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    typedef enum logic [1:0] {StStableLo, StChkHi, StStableHi, StChkLo} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   busy_q;

    // Only stage 0 ever sees din, so metastability stays in the first flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StStableLo;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            busy_q  <= (state_d == StChkHi) || (state_d == StChkLo);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStableLo: if (sync) state_d = StChkHi;
            StChkHi: begin
                if (!sync) begin
                    state_d = StStableLo;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StStableHi;
                end
            end
            StStableHi: if (!sync) state_d = StChkLo;
            StChkLo: begin
                if (sync) begin
                    state_d = StStableHi;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StStableLo;
                end
            end
            default: state_d = StStableLo;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        rise_d = 1'b0;
        unique case (state_q)
            StStableLo: if (sync) cnt_d = '0;
            StChkHi: begin
                if (sync) begin
                    if (cnt_q == CNT_LAST) begin
                        dout_d = 1'b1;
                        rise_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StStableHi: if (!sync) cnt_d = '0;
            StChkLo: begin
                if (!sync) begin
                    if (cnt_q == CNT_LAST) begin
                        dout_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

`ifdef DEBOUNCE_FALL_PULSE_EN
    logic fall_q, fall_d;

    always_comb begin
        fall_d = (state_q == StChkLo) && !sync && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= fall_d;
        end
    end

    assign fall = fall_q;
`else
    assign fall = 1'b0;
`endif

    assign dout = dout_q;
    assign rise = rise_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Randomized bench for debounce_sync: a run-length reference model checked every cycle,
// plus literal checks of the reset, latency, glitch, fall, mid-reset and bounce cases.
module tb_debounce_sync;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_MAX     = 4;
`ifdef DEBOUNCE_FALL_PULSE_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic din   = 1'b0;
    logic dout, rise, fall, busy;

    int checks = 0;
    int errors = 0;

    // Reference model: sync is din delayed by SYNC_STAGES samples; dout flips once the
    // FSM has seen CNT_MAX+1 consecutive samples differing from the current level.
    bit m_dout, m_rise, m_fall, m_busy;
    int run;
    bit dq[$];

    int n_rise, n_fall, n_up;
    bit prev_dout;

    debounce_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_MAX    (CNT_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        dq = {};
        for (int i = 0; i < int'(SYNC_STAGES); i++) dq.push_back(1'b0);
        m_dout = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_busy = 1'b0;
        run    = 0;
    endtask

    initial begin
        bit s;
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_clear();
            end else begin
                s = dq.pop_front();
                dq.push_back(din);
                m_rise = 1'b0;
                m_fall = 1'b0;
                if (s != m_dout) begin
                    run++;
                    if (run == int'(CNT_MAX) + 1) begin
                        m_dout = s;
                        m_rise = s;
                        m_fall = !s && FALL_EN;
                        run    = 0;
                    end
                end else begin
                    run = 0;
                end
                m_busy = (run > 0);
            end
        end
    end

    initial begin
        prev_dout = 1'b0;
        forever begin
            @(negedge clk);
            chk("dout_model", dout, m_dout);
            chk("rise_model", rise, m_rise);
            chk("fall_model", fall, m_fall);
            chk("busy_model", busy, m_busy);
            if (rise) n_rise++;
            if (fall) n_fall++;
            if (dout && !prev_dout) n_up++;
            prev_dout = dout;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic d, input logic r, input logic f,
                           input logic b);
        chk({name, "_dout"}, dout, d);
        chk({name, "_rise"}, rise, r);
        chk({name, "_fall"}, fall, f);
        chk({name, "_busy"}, busy, b);
    endtask

    initial begin
        // 1. reset held three cycles
        reset = 1'b1;
        din   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk_all("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        step(3);
        chk_all("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);

        // 2. clean rise; din first sampled at the next edge (edge 1)
        din = 1'b1;
        step(2);
        chk("rise_e2_busy", busy, 1'b0);
        step(1);
        chk("rise_e3_busy", busy, 1'b1);
        step(3);
        chk("rise_e6_dout", dout, 1'b0);
        step(1);
        chk_all("rise_e7", 1'b1, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_all("rise_e8", 1'b1, 1'b0, 1'b0, 1'b0);
        step(4);

        // 4. clean fall
        din = 1'b0;
        step(6);
        chk("fall_e6_dout", dout, 1'b1);
        step(1);
        chk_all("fall_e7", 1'b0, 1'b0, FALL_EN, 1'b0);
        step(1);
        chk_all("fall_e8", 1'b0, 1'b0, 1'b0, 1'b0);
        step(4);

        // 3. two-cycle glitch from stable low
        n_rise = 0;
        din = 1'b1;
        step(2);
        din = 1'b0;
        step(12);
        chk_all("glitch", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("glitch_no_rise", logic'(n_rise == 0), 1'b1);

        // 5. reset while in CHK_HI with cnt=2 (after edge 5), then release with din=1
        din = 1'b1;
        step(5);
        chk("mid_busy_before", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_all("mid_rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        @(negedge clk);
        reset = 1'b0;
        n_rise = 0;
        step(6);
        chk("mid_e6_dout", dout, 1'b0);
        step(1);
        chk_all("mid_e7", 1'b1, 1'b1, 1'b0, 1'b0);
        step(3);
        chk("mid_one_rise", logic'(n_rise == 1), 1'b1);

        // 6. bounce from stable low, then hold high
        din = 1'b0;
        step(12);
        n_rise = 0;
        n_fall = 0;
        n_up   = 0;
        for (int i = 0; i < 10; i++) begin
            din = (i % 2 == 0);
            step(1);
        end
        din = 1'b1;
        step(15);
        chk("bounce_dout", dout, 1'b1);
        chk("bounce_one_rise", logic'(n_rise == 1), 1'b1);
        chk("bounce_one_up", logic'(n_up == 1), 1'b1);
        chk("bounce_no_fall", logic'(n_fall == 0), 1'b1);

        // randomized runs with occasional asynchronous reset
        for (int i = 0; i < 400; i++) begin
            din = 1'($urandom_range(0, 1));
            step($urandom_range(1, 8));
            if ($urandom_range(0, 39) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                chk_all("rand_rst", 1'b0, 1'b0, 1'b0, 1'b0);
                step($urandom_range(1, 3));
                @(negedge clk);
                reset = 1'b0;
            end
        end
        step(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
